mini_fir_seq: RTL and testbench

- Sequencer that time-multiplexes one unsigned 8x8 MAC stage (19-bit registered accumulate, 1-cycle latency) across an 8-tap FIR.
- Holds the sample delay line and the coefficient bank.
- Accepts one input sample per valid/ready handshake and steps the MAC through all taps.
- Returns the 19-bit filter sum on a valid/ready output.

---
 rtl/mini_fir_seq_if.sv | 38 +++
 rtl/mini_fir_seq.sv | 82 ++++++++
 tb/tb_mini_fir_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mini_fir_seq_if.sv
// Signal bundle for the mini_fir_seq sequencer: sample stream, coefficient port,
// external MAC stage and result stream. The slave modport is the sequencer's view.
interface mini_fir_seq_if #(
  parameter int TAPS = 8,
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int AW   = 19
);
  localparam int TW = $clog2(TAPS);

  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;

  logic          i_cfg_we;
  logic [TW-1:0] i_cfg_addr;
  logic [CW-1:0] i_cfg_coeff;
  logic          o_cfg_drop;

  logic [DW-1:0] o_mac_data;
  logic [CW-1:0] o_mac_coeff;
  logic [AW-1:0] o_mac_prev;
  logic [AW-1:0] i_mac_next;

  logic          o_valid;
  logic          i_ready;
  logic [AW-1:0] o_result;

  modport slave (
    input  i_valid, i_data, i_cfg_we, i_cfg_addr, i_cfg_coeff, i_mac_next, i_ready,
    output o_ready, o_cfg_drop, o_mac_data, o_mac_coeff, o_mac_prev, o_valid, o_result
  );

  modport master (
    output i_valid, i_data, i_cfg_we, i_cfg_addr, i_cfg_coeff, i_mac_next, i_ready,
    input  o_ready, o_cfg_drop, o_mac_data, o_mac_coeff, o_mac_prev, o_valid, o_result
  );
endinterface

// File: rtl/mini_fir_seq.sv
// Time-multiplexes one external registered 8x8 MAC across an 8-tap FIR: holds the
// delay line and coefficient bank, steps the MAC through each tap, returns the sum.
module mini_fir_seq #(
  parameter int TAPS = 8,
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int AW   = 19
) (
  input logic           clk,
  input logic           rst,
  mini_fir_seq_if.slave bus
);
  localparam int TW = $clog2(TAPS);

  typedef enum logic [1:0] {IDLE, RUN, LAST, HOLD} state_t;

  state_t        state;
  logic [TW-1:0] tap;
  logic [DW-1:0] x    [TAPS];
  logic [CW-1:0] coef [TAPS];

  assign bus.o_ready = (state == IDLE);

  // The MAC sees operands only while stepping taps; tap 0 starts a fresh sum.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    bus.o_mac_data  = '0;
    bus.o_mac_coeff = '0;
    bus.o_mac_prev  = '0;
    if (state == RUN) begin
      bus.o_mac_data  = x[tap];
      bus.o_mac_coeff = coef[tap];
      bus.o_mac_prev  = (tap == '0) ? '0 : bus.i_mac_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the delay line and coefficient bank are architecturally visible after
      // reset (a following sample must yield 0), so these arrays are cleared too.
      state        <= IDLE;
      tap          <= '0;
      bus.o_result <= '0;
      bus.o_valid  <= 1'b0;
      bus.o_cfg_drop <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x[k]    <= '0;
        coef[k] <= '0;
      end
    end else begin
      bus.o_cfg_drop <= bus.i_cfg_we && (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.i_cfg_we) coef[bus.i_cfg_addr] <= bus.i_cfg_coeff;
          if (bus.i_valid) begin
            x[0] <= bus.i_data;
            for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
            tap   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          tap <= tap + 1'b1;
          if (tap == TW'(TAPS - 1)) state <= LAST;
        end
        LAST: begin
          // i_mac_next now carries the last tap's accumulate, i.e. the full sum.
          bus.o_result <= bus.i_mac_next;
          bus.o_valid  <= 1'b1;
          state        <= HOLD;
        end
        HOLD: begin
          if (bus.i_ready) begin
            bus.o_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mini_fir_seq.sv
// Self-checking bench for mini_fir_seq: models the external MAC, checks results
// against a queue-based FIR reference, table vectors and multi-cycle corner cases.
module tb_mini_fir_seq;
  localparam int TAPS = 8;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int AW   = 19;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mini_fir_seq_if #(.TAPS(TAPS), .DW(DW), .CW(CW), .AW(AW)) bus ();

  mini_fir_seq #(.TAPS(TAPS), .DW(DW), .CW(CW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External registered MAC stage: next = prev + data*coeff, one-cycle latency.
  always @(posedge clk)
    bus.i_mac_next <= bus.o_mac_prev + AW'(bus.o_mac_data) * AW'(bus.o_mac_coeff);

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: newest sample at the front of the history queue.
  int hist[$];
  int m_c [TAPS];

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] exp;
  } vec_t;
  vec_t tbl[16];

  function automatic int model_sum();
    int s = 0;
    for (int k = 0; k < TAPS; k++) s += hist[k] * m_c[k];
    return s;
  endfunction

  task automatic model_clear();
    hist.delete();
    for (int k = 0; k < TAPS; k++) begin
      hist.push_back(0);
      m_c[k] = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.o_ready !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {31'd0, bus.o_ready}, 32'd1);
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [CW-1:0] c);
    wait_ready();
    bus.i_cfg_we = 1'b1; bus.i_cfg_addr = a; bus.i_cfg_coeff = c;
    m_c[a] = int'(c);
    @(posedge clk); @(negedge clk);
    bus.i_cfg_we = 1'b0;
    check("idle_write_no_drop", {31'd0, bus.o_cfg_drop}, 32'd0);
  endtask

  // Accept one sample (optionally with an IDLE write alongside, or a write issued
  // mid-RUN), wait for the result and compare latency and value with the model.
  task automatic push_sample(input logic [DW-1:0] d, input bit idle_we, input bit run_we,
                             input logic [2:0] a, input logic [CW-1:0] c,
                             output logic [AW-1:0] res);
    int n;
    wait_ready();
    bus.i_valid = 1'b1; bus.i_data = d;
    if (idle_we) begin
      bus.i_cfg_we = 1'b1; bus.i_cfg_addr = a; bus.i_cfg_coeff = c;
      m_c[a] = int'(c);
    end
    hist.push_front(int'(d));
    void'(hist.pop_back());
    @(posedge clk); @(negedge clk);
    bus.i_valid = 1'b0; bus.i_cfg_we = 1'b0;
    check("busy_after_accept", {31'd0, bus.o_ready}, 32'd0);
    check("valid_low_in_run", {31'd0, bus.o_valid}, 32'd0);
    n = 0;
    while (n < 30) begin
      if (run_we && n == 2) begin
        bus.i_cfg_we = 1'b1; bus.i_cfg_addr = a; bus.i_cfg_coeff = c;
      end
      @(posedge clk); @(negedge clk);
      n++;
      if (run_we && n == 3) begin
        bus.i_cfg_we = 1'b0;
        check("drop_pulse", {31'd0, bus.o_cfg_drop}, 32'd1);
      end
      if (run_we && n == 4) check("drop_clear", {31'd0, bus.o_cfg_drop}, 32'd0);
      if (bus.o_valid === 1'b1) break;
    end
    check("latency", n, 32'd9);
    check("result", 32'(bus.o_result), model_sum());
    res = bus.o_result;
  endtask

  task automatic accept_result();
    bus.i_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.i_ready = 1'b0;
    check("valid_falls", {31'd0, bus.o_valid}, 32'd0);
    check("ready_after_accept", {31'd0, bus.o_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] res;
    logic          stable;
    int            hold;

    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin
        tbl[i].data = (i == 0) ? 8'd1 : 8'd0;
        tbl[i].exp  = AW'(i + 1);
      end else begin
        tbl[i].data = 8'd255;
        tbl[i].exp  = AW'(65025 * (i - 7));
      end
    end

    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_cfg_we = 1'b0;
    bus.i_cfg_addr = '0; bus.i_cfg_coeff = '0; bus.i_ready = 1'b0;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", {31'd0, bus.o_ready}, 32'd1);
    check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_result", 32'(bus.o_result), 32'd0);
    check("rst_drop", {31'd0, bus.o_cfg_drop}, 32'd0);
    check("idle_mac_prev", 32'(bus.o_mac_prev), 32'd0);
    check("idle_mac_ops", {16'd0, bus.o_mac_data, bus.o_mac_coeff}, 32'd0);

    // Impulse response through ramp coefficients, then full-scale saturation-free sums.
    for (int i = 0; i < 16; i++) begin
      if (i == 0) for (int k = 0; k < TAPS; k++) cfg_write(3'(k), CW'(k + 1));
      if (i == 8) for (int k = 0; k < TAPS; k++) cfg_write(3'(k), 8'd255);
      push_sample(tbl[i].data, 1'b0, 1'b0, 3'd0, 8'd0, res);
      check("tbl_result", 32'(res), 32'(tbl[i].exp));
      accept_result();
    end

    // Downstream stall: result and valid must hold, no new sample accepted.
    push_sample(8'd5, 1'b0, 1'b0, 3'd0, 8'd0, res);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      stable = (bus.o_valid === 1'b1) && (bus.o_result === res) && (bus.o_ready === 1'b0);
      check("hold_stable", {31'd0, stable}, 32'd1);
    end
    accept_result();

    // Write during RUN is dropped; same write alongside an accept is used at once.
    push_sample(8'd7, 1'b0, 1'b1, 3'd3, 8'd9, res);
    accept_result();
    push_sample(8'd3, 1'b1, 1'b0, 3'd3, 8'd9, res);
    check("new_coef_used", 32'(res), 32'(3*255 + 7*255 + 5*255 + 255*9 + 4*255*255));
    accept_result();

    // Randomized traffic against the model.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0) cfg_write(3'($urandom_range(0, 7)), CW'($urandom_range(0, 255)));
      push_sample(DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), CW'($urandom_range(0, 255)), res);
      hold = $urandom_range(0, 3);
      repeat (hold) @(negedge clk);
      accept_result();
    end

    // Reset at tap 4 discards the in-flight sum and clears the filter state.
    wait_ready();
    bus.i_valid = 1'b1; bus.i_data = 8'h55;
    @(posedge clk); @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_clear();
    check("midrun_rst_ready", {31'd0, bus.o_ready}, 32'd1);
    check("midrun_rst_valid", {31'd0, bus.o_valid}, 32'd0);
    stable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.o_valid !== 1'b0) stable = 1'b0;
    end
    check("no_stale_valid", {31'd0, stable}, 32'd1);
    push_sample(8'd200, 1'b0, 1'b0, 3'd0, 8'd0, res);
    check("post_rst_zero", 32'(res), 32'd0);
    accept_result();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
